// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, LSB-first data, optional parity and stop
// bits, one bit per clock, and drives the line-mux select for an external serializer.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  ser_data_q, ser_data_d;
  logic                  load;

  // NOTE: every signal gets its default before the case statement, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    ser_data_d = ser_data_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Data_Valid) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d    = ST_DATA;
        cnt_d      = '0;
        ser_data_d = data_q[0];
      end
      ST_DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ser_data_d = data_q[cnt_d];
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
        // Back-to-back requests skip IDLE entirely.
        if (Data_Valid) begin
          load    = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every register here is
  // reset because outputs must be defined the instant RST rises.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      ser_data_q <= ser_data_d;
    end
  end

  // Outputs decode registered state only; nothing reaches them from the inputs.
  always_comb begin
    mux_sel = 2'b11;
    case (state_q)
      ST_START:  mux_sel = 2'b00;
      ST_DATA:   mux_sel = 2'b01;
      ST_PARITY: mux_sel = 2'b10;
      default:   mux_sel = 2'b11;
    endcase
  end

  assign busy     = (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign ser_data = ser_data_q;
  assign par_bit  = (^data_q) ^ par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a frame-level model predicts accepted frames and
// their start cycles; an independent monitor reassembles each frame from the outputs.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [1:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    bit            pe;
    bit            pt;
    int unsigned   start;
  } frame_t;

  frame_t      sb_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          rem = 0;   // model: cycles left in the visible frame, 0 = idle

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_parity(input frame_t f);
    return bit'($countones(f.data) % 2) ^ f.pt;
  endfunction

  // One bit period of stimulus, called at a falling edge; the model decides acceptance.
  task automatic step(input bit dv, input logic [DW-1:0] d, input bit pe, input bit pt);
    frame_t f;
    Data_Valid = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    if (dv && rem <= 1) begin
      f.data  = d;
      f.pe    = pe;
      f.pt    = pt;
      f.start = cyc + 1;
      sb_q.push_back(f);
      rem = 2 + DW + int'(pe);
    end else if (rem > 0) begin
      rem--;
    end
    @(negedge CLK);
  endtask

  task automatic step_idle();
    step(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt);
    step(1'b1, d, pe, pt);
  endtask

  task automatic drain();
    int n = 0;
    while ((rem > 0 || sb_q.size() > 0) && n < 64) begin
      step_idle();
      n++;
    end
    step_idle();
    check("drain_queue", sb_q.size(), 0);
  endtask

  // Monitor: reassembles one frame starting at a START cycle and scores it.
  task automatic mon_frame();
    frame_t        f;
    int            len;
    logic [DW-1:0] got;
    logic [1:0]    em;
    bit            seq_ok, busy_ok, par_stable, par_seen;
    if (sb_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    f          = sb_q.pop_front();
    check("start_cycle", cyc, f.start);
    len        = 2 + DW + int'(f.pe);
    got        = '0;
    seq_ok     = 1'b1;
    busy_ok    = busy;
    par_seen   = par_bit;
    par_stable = 1'b1;
    for (int i = 1; i < len; i++) begin
      @(negedge CLK);
      if (RST) return;
      if (i <= DW)                    em = 2'b01;
      else if (f.pe && i == DW + 1)   em = 2'b10;
      else                            em = 2'b11;
      if (mux_sel !== em) seq_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (par_bit !== par_seen) par_stable = 1'b0;
      if (i <= DW) got[i-1] = ser_data;
    end
    check("mux_sequence", seq_ok, 1);
    check("busy_in_frame", busy_ok, 1);
    check("par_bit", par_seen, exp_parity(f));
    check("par_stable", par_stable, 1);
    check("ser_data_bits", got, f.data);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && mux_sel == 2'b00) mon_frame();
      else check("idle_outputs", {busy, mux_sel}, 3'b011);
    end
  end

  initial begin
    #1 RST = 1'b1;
    #2;
    check("rst_mux_sel", mux_sel, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_par_bit", par_bit, 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);

    // Basic frames: with and without parity, and the parity-type corner cases.
    send(8'hA5, 1'b1, 1'b0); drain();
    send(8'hA5, 1'b0, 1'b0); drain();
    send(8'h01, 1'b1, 1'b1); drain();
    send(8'h00, 1'b1, 1'b1); drain();

    // Data_Valid held high: the second frame must start right after STOP.
    send(8'h3C, 1'b1, 1'b0);
    while (rem > 1) step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    drain();

    // A request pulsed mid-DATA must be dropped without touching the payload.
    send(8'h00, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    drain();

    // Random requests, with inputs churning every cycle.
    repeat (400) step(($urandom_range(0, 2) == 0), DW'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Reset at DATA bit 3 must take effect between clock edges.
    send(8'h96, 1'b1, 1'b1);
    while (rem > 2 + DW + 1 - 4) step_idle();
    #2 RST = 1'b1;
    #1;
    check("midrst_mux_sel", mux_sel, 2'b11);
    check("midrst_busy", busy, 0);
    check("midrst_ser_data", ser_data, 0);
    check("midrst_par_bit", par_bit, 0);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    rem = 0;
    sb_q.delete();
    @(negedge CLK);
    repeat (6) step_idle();
    check("post_rst_idle", {busy, mux_sel}, 3'b011);

    // First request after release is accepted normally.
    send(8'hC3, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame (legal range 5..9).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; one clock cycle equals one bit period.
REQ-003 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port P_DATA, input, DATA_WIDTH, the parallel payload, sampled only on acceptance.
REQ-005 The block SHALL have port Data_Valid, input, 1, a frame request qualifying P_DATA, PAR_EN and PAR_TYP.
REQ-006 The block SHALL have port PAR_EN, input, 1, where 1 inserts a parity bit, sampled on acceptance.
REQ-007 The block SHALL have port PAR_TYP, input, 1, where 0 selects even and 1 selects odd parity, sampled on acceptance.
REQ-008 The block SHALL have port mux_sel, output, 2, the line-mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
REQ-009 The block SHALL have port ser_data, output, 1, the current payload bit.
REQ-010 The block SHALL have port par_bit, output, 1, the parity of the latched frame.
REQ-011 The block SHALL have port busy, output, 1, which is high while a frame is in progress.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with all outputs registered or decoded from registered state only (no input-to-output combinational path).
REQ-013 In IDLE, mux_sel SHALL be 11 and busy SHALL be 0.
REQ-014 A frame SHALL be accepted when Data_Valid=1 at a rising edge while in IDLE or STOP.
REQ-015 On acceptance, the block SHALL latch P_DATA, PAR_EN and PAR_TYP and enter START on that edge.
REQ-016 Data_Valid in START, DATA or PARITY SHALL be ignored: no latch, no queueing, and in-flight data SHALL be unaffected.
REQ-017 START SHALL last exactly 1 cycle with mux_sel=00 and busy=1, then go to DATA.
REQ-018 DATA SHALL last exactly DATA_WIDTH cycles with mux_sel=01, and ser_data SHALL present the latched bits LSB first, one bit per cycle.
REQ-019 A bit counter of width ceil(log2(DATA_WIDTH)) SHALL clear on entry to DATA and SHALL exit DATA when it reaches DATA_WIDTH-1.
REQ-020 After DATA, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-021 PARITY SHALL last 1 cycle with mux_sel=10.
REQ-022 par_bit SHALL be the XOR of all latched data bits, inverted when latched PAR_TYP=1, and SHALL be stable from START through STOP.
REQ-023 STOP SHALL last 1 cycle with mux_sel=11 and busy=1.
REQ-024 STOP SHALL go to START if Data_Valid=1 (back-to-back, no idle cycle), else to IDLE.
REQ-025 Frame length SHALL be 2+DATA_WIDTH+PAR_EN cycles, from the first START cycle to the last STOP cycle inclusive.
REQ-026 Changes to PAR_EN, PAR_TYP or P_DATA mid-frame SHALL NOT affect the current frame.
REQ-027 When not in DATA, ser_data SHALL hold the last driven value and is don't-care to the line, because mux_sel is not 01.
REQ-028 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-029 RST=1 SHALL immediately, without waiting for a clock edge, force state IDLE, mux_sel=11, busy=0, ser_data=0, par_bit=0, bit counter=0 and latched registers=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, and no partial frame SHALL resume after release.
REQ-031 The first acceptance SHALL be possible at the first rising edge after RST deasserts.

Verification
REQ-032 Scenario: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid in IDLE -> mux_sel 00, then 01×8, then 10, then 11; ser_data 1,0,1,0,0,1,0,1; par_bit=0; busy high for 11 cycles.
REQ-033 Scenario: same data with PAR_EN=0 -> no 10 cycle, frame is 10 cycles, busy falls after STOP.
REQ-034 Scenario: P_DATA=8'h01, PAR_TYP=1 -> par_bit=0; with P_DATA=8'h00 and PAR_TYP=1 -> par_bit=1.
REQ-035 Scenario: Data_Valid held high continuously with frames 8'h3C then 8'h55 -> STOP is followed directly by START, with no IDLE cycle between frames.
REQ-036 Scenario: Data_Valid pulsed with P_DATA=8'hFF during DATA of frame 8'h00 -> ser_data stays 0 for all 8 bits, and no extra frame is sent.
REQ-037 Scenario: RST asserted at DATA bit 3 -> mux_sel=11 and busy=0 within the same cycle with no clock edge, and the FSM stays in IDLE after release until Data_Valid.
